// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the multicycle ARM controller: FSM states, datapath
// select codes, opcode classes and condition-field values.
package arm_ctrl_pkg;

   typedef logic [3:0] state_t;

   localparam state_t S_FETCH  = 4'd0;
   localparam state_t S_DECODE = 4'd1;
   localparam state_t S_MEMADR = 4'd2;
   localparam state_t S_MEMRD  = 4'd3;
   localparam state_t S_MEMWB  = 4'd4;
   localparam state_t S_MEMWR  = 4'd5;
   localparam state_t S_EXECR  = 4'd6;
   localparam state_t S_EXECI  = 4'd7;
   localparam state_t S_ALUWB  = 4'd8;
   localparam state_t S_BRANCH = 4'd9;

   localparam logic [1:0] SRCA_REG  = 2'b00;
   localparam logic [1:0] SRCA_PC   = 2'b01;
   localparam logic [1:0] SRCA_AOUT = 2'b10;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_AOUT  = 2'b00;
   localparam logic [1:0] RES_DATA  = 2'b01;
   localparam logic [1:0] RES_ALU   = 2'b10;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_AND   = 2'b10;
   localparam logic [1:0] ALU_ORR   = 2'b11;

   localparam logic [1:0] OP_DP     = 2'b00;
   localparam logic [1:0] OP_MEM    = 2'b01;
   localparam logic [1:0] OP_BR     = 2'b10;
   localparam logic [1:0] OP_NOP    = 2'b11;

   localparam logic [3:0] CMD_AND   = 4'b0000;
   localparam logic [3:0] CMD_SUB   = 4'b0010;
   localparam logic [3:0] CMD_ADD   = 4'b0100;
   localparam logic [3:0] CMD_CMP   = 4'b1010;
   localparam logic [3:0] CMD_ORR   = 4'b1100;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

endpackage

// File: rtl/arm_controller_condlogic.sv
// Stored NZCV flags, per-instruction condition latch and the write-enable
// gating that depends on it.
module condlogic
   import arm_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] cond_i,
   input  logic [3:0] aluflags_i,
   input  logic [1:0] flagw_i,
   input  logic       capture_i,
   input  logic       pcs_i,
   input  logic       nextpc_i,
   input  logic       regw_i,
   input  logic       memw_i,
   input  logic       nowrite_i,
   output logic       pcwrite_o,
   output logic       regwrite_o,
   output logic       memwrite_o
);

   logic [3:0] flags_q;
   logic       condex_q;
   logic       cond_met;
   logic       n, z, c, v;

   assign {n, z, c, v} = flags_q;

   always_comb begin
      cond_met = 1'b0;
      case (cond_i)
         COND_EQ: cond_met = z;
         COND_NE: cond_met = ~z;
         COND_CS: cond_met = c;
         COND_CC: cond_met = ~c;
         COND_MI: cond_met = n;
         COND_PL: cond_met = ~n;
         COND_VS: cond_met = v;
         COND_VC: cond_met = ~v;
         COND_HI: cond_met = c & ~z;
         COND_LS: cond_met = ~c | z;
         COND_GE: cond_met = (n == v);
         COND_LT: cond_met = (n != v);
         COND_GT: cond_met = ~z & (n == v);
         COND_LE: cond_met = z | (n != v);
         COND_AL: cond_met = 1'b1;
         default: cond_met = 1'b0;
      endcase
   end

   // condex_q holds the decision for the whole instruction, so flag writes
   // in EXECUTE cannot change whether this instruction commits.
   always_ff @(posedge clk) begin
      if (reset) begin
         flags_q  <= 4'b0000;
         condex_q <= 1'b0;
      end else begin
         if (capture_i)              condex_q      <= cond_met;
         if (flagw_i[1] & condex_q)  flags_q[3:2]  <= aluflags_i[3:2];
         if (flagw_i[0] & condex_q)  flags_q[1:0]  <= aluflags_i[1:0];
      end
   end

   assign pcwrite_o  = nextpc_i | (pcs_i & condex_q);
   assign regwrite_o = regw_i & condex_q & ~nowrite_i;
   assign memwrite_o = memw_i & condex_q;

endmodule

// File: rtl/arm_controller.sv
// Multicycle ARM control unit: main FSM, Moore output decode and ALU decode;
// condition checking and write gating live in condlogic.
module arm_controller
   import arm_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [19:0] Instr,
   input  logic [3:0]  ALUFlags,
   output logic        PCWrite,
   output logic        MemWrite,
   output logic        RegWrite,
   output logic        IRWrite,
   output logic        AdrSrc,
   output logic [1:0]  RegSrc,
   output logic [1:0]  ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ResultSrc,
   output logic [1:0]  ImmSrc,
   output logic [1:0]  ALUControl
);

   logic [3:0] cond, rd;
   logic [1:0] op;
   logic [5:0] funct;
   logic       unused_instr;

   assign cond         = Instr[19:16];
   assign op           = Instr[15:14];
   assign funct        = Instr[13:8];
   assign rd           = Instr[3:0];
   assign unused_instr = ^Instr[7:4];

   state_t state_q, state_d, st;

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: case (op)
                      OP_MEM:  state_d = S_MEMADR;
                      OP_DP:   state_d = funct[5] ? S_EXECI : S_EXECR;
                      OP_BR:   state_d = S_BRANCH;
                      default: state_d = S_FETCH;
                   endcase
         S_MEMADR: state_d = funct[0] ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_d = S_MEMWB;
         S_EXECR,
         S_EXECI:  state_d = S_ALUWB;
         default:  state_d = S_FETCH;
      endcase
   end

   // While reset is high the selects show FETCH values and every enable is
   // suppressed, regardless of where the FSM was interrupted.
   assign st = reset ? S_FETCH : state_q;

   logic irw, nextpc, regw, memw, branch, aluop;

   always_comb begin
      irw = 1'b0; nextpc = 1'b0; regw = 1'b0; memw = 1'b0;
      branch = 1'b0; aluop = 1'b0; AdrSrc = 1'b0;
      ALUSrcA = SRCA_REG; ALUSrcB = SRCB_REG; ResultSrc = RES_AOUT;
      case (st)
         S_FETCH:  begin irw = 1'b1; nextpc = 1'b1;
                         ALUSrcA = SRCA_PC; ALUSrcB = SRCB_FOUR; ResultSrc = RES_ALU; end
         S_DECODE: begin ALUSrcA = SRCA_PC; ALUSrcB = SRCB_FOUR; ResultSrc = RES_ALU; end
         S_MEMADR: ALUSrcB = SRCB_IMM;
         S_MEMRD:  AdrSrc = 1'b1;
         S_MEMWB:  begin ResultSrc = RES_DATA; regw = 1'b1; end
         S_MEMWR:  begin AdrSrc = 1'b1; memw = 1'b1; end
         S_EXECR:  aluop = 1'b1;
         S_EXECI:  begin ALUSrcB = SRCB_IMM; aluop = 1'b1; end
         S_ALUWB:  regw = 1'b1;
         S_BRANCH: begin ALUSrcA = SRCA_AOUT; ALUSrcB = SRCB_IMM;
                         ResultSrc = RES_ALU; branch = 1'b1; end
         default:  ;
      endcase
   end

   logic [1:0] flagw;
   logic       nowrite, pcs;

   always_comb begin
      ALUControl = ALU_ADD;
      flagw      = 2'b00;
      if (aluop) begin
         case (funct[4:1])
            CMD_ADD: begin ALUControl = ALU_ADD; flagw = {2{funct[0]}};     end
            CMD_SUB,
            CMD_CMP: begin ALUControl = ALU_SUB; flagw = {2{funct[0]}};     end
            CMD_AND: begin ALUControl = ALU_AND; flagw = {funct[0], 1'b0}; end
            CMD_ORR: begin ALUControl = ALU_ORR; flagw = {funct[0], 1'b0}; end
            default: begin ALUControl = ALU_ADD; flagw = 2'b00;            end
         endcase
      end
   end

   // CMP suppresses its writeback in ALUWB, where ALUOp is already low,
   // so this is decoded from the instruction alone.
   assign nowrite = (op == OP_DP) & (funct[4:1] == CMD_CMP);
   assign pcs     = branch | (regw & (rd == 4'hF));
   assign RegSrc  = {op == OP_MEM, op == OP_BR};
   assign ImmSrc  = op;
   assign IRWrite = irw & ~reset;

   condlogic u_cond (
      .clk        (clk),
      .reset      (reset),
      .cond_i     (cond),
      .aluflags_i (ALUFlags),
      .flagw_i    (flagw),
      .capture_i  (st == S_DECODE),
      .pcs_i      (pcs & ~reset),
      .nextpc_i   (nextpc & ~reset),
      .regw_i     (regw & ~reset),
      .memw_i     (memw & ~reset),
      .nowrite_i  (nowrite),
      .pcwrite_o  (PCWrite),
      .regwrite_o (RegWrite),
      .memwrite_o (MemWrite)
   );

endmodule

// File: tb/tb_arm_controller.sv
// Cycle-by-cycle check of the ARM controller against hand-derived control
// words for a short program, including reset in mid-instruction.
module tb_arm_controller;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [19:0] Instr = '0;
   logic [3:0]  ALUFlags = '0;
   logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
   logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;

   arm_controller dut (
      .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
      .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
      .IRWrite(IRWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
      .ImmSrc(ImmSrc), .ALUControl(ALUControl)
   );

   always #5 clk = ~clk;

   // en = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc}
   typedef struct packed {
      logic [4:0] en;
      logic [1:0] rs, sa, sb, re, im, al;
   } out_t;

   typedef struct {
      logic        rst;
      logic [19:0] ins;
      logic [3:0]  af;
      out_t        exp;
   } vec_t;

   localparam logic [19:0] I_ADD   = 20'hE0802;
   localparam logic [19:0] I_LDR   = 20'hE5901;
   localparam logic [19:0] I_STR   = 20'hE5801;
   localparam logic [19:0] I_SUBS  = 20'hE0503;
   localparam logic [19:0] I_BEQ   = 20'h0A000;
   localparam logic [19:0] I_BNE   = 20'h1A000;
   localparam logic [19:0] I_CMP   = 20'hE3500;
   localparam logic [19:0] I_ADDEQ = 20'h02811;
   localparam logic [19:0] I_ADDPC = 20'hE080F;
   localparam logic [19:0] I_BMI   = 20'h4A000;
   localparam logic [19:0] I_NOP   = 20'hEC000;

   out_t exp_q[$];
   vec_t tbl[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic vec_t V(input logic rst, input logic [19:0] ins,
                              input logic [3:0] af, input logic [4:0] en,
                              input logic [1:0] rs, sa, sb, re, im, al);
      vec_t r;
      r.rst = rst; r.ins = ins; r.af = af;
      r.exp = '{en:en, rs:rs, sa:sa, sb:sb, re:re, im:im, al:al};
      return r;
   endfunction

   // FETCH and DECODE rows only differ by instruction class (RegSrc/ImmSrc)
   function automatic vec_t VF(input logic [19:0] ins, input logic [1:0] rs, im);
      return V(1'b0, ins, 4'h0, 5'b10010, rs, 2'b01, 2'b10, 2'b10, im, 2'b00);
   endfunction
   function automatic vec_t VD(input logic [19:0] ins, input logic [1:0] rs, im);
      return V(1'b0, ins, 4'h0, 5'b00000, rs, 2'b01, 2'b10, 2'b10, im, 2'b00);
   endfunction

   task automatic step(input vec_t v, input int idx);
      out_t got, exp;
      @(negedge clk);
      reset = v.rst; Instr = v.ins; ALUFlags = v.af;
      exp_q.push_back(v.exp);
      #2;
      got = '{en:{PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc}, rs:RegSrc,
              sa:ALUSrcA, sb:ALUSrcB, re:ResultSrc, im:ImmSrc, al:ALUControl};
      exp = exp_q.pop_front();
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL ctl[%0d] instr=%h: got en=%b rs=%b sa=%b sb=%b re=%b im=%b al=%b, expected en=%b rs=%b sa=%b sb=%b re=%b im=%b al=%b",
                  idx, v.ins, got.en, got.rs, got.sa, got.sb, got.re, got.im, got.al,
                  exp.en, exp.rs, exp.sa, exp.sb, exp.re, exp.im, exp.al);
      end
   endtask

   initial begin
      // reset cycle: FETCH selects, no enables
      tbl.push_back(V(1, I_ADD, 0, 5'b00000, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00));
      // ADD R2,R0,R1
      tbl.push_back(VF(I_ADD, 2'b00, 2'b00));
      tbl.push_back(VD(I_ADD, 2'b00, 2'b00));
      tbl.push_back(V(0, I_ADD, 0, 5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
      tbl.push_back(V(0, I_ADD, 0, 5'b00100, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
      // LDR R1,[R0,#4]
      tbl.push_back(VF(I_LDR, 2'b10, 2'b01));
      tbl.push_back(VD(I_LDR, 2'b10, 2'b01));
      tbl.push_back(V(0, I_LDR, 0, 5'b00000, 2'b10, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00));
      tbl.push_back(V(0, I_LDR, 0, 5'b00001, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00));
      tbl.push_back(V(0, I_LDR, 0, 5'b00100, 2'b10, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00));
      // STR
      tbl.push_back(VF(I_STR, 2'b10, 2'b01));
      tbl.push_back(VD(I_STR, 2'b10, 2'b01));
      tbl.push_back(V(0, I_STR, 0, 5'b00000, 2'b10, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00));
      tbl.push_back(V(0, I_STR, 0, 5'b01001, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00));
      // SUBS R3,R0,R0 with ALUFlags=0110 in EXECUTER
      tbl.push_back(VF(I_SUBS, 2'b00, 2'b00));
      tbl.push_back(VD(I_SUBS, 2'b00, 2'b00));
      tbl.push_back(V(0, I_SUBS, 4'b0110, 5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01));
      tbl.push_back(V(0, I_SUBS, 0, 5'b00100, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
      // BEQ taken (Z=1)
      tbl.push_back(VF(I_BEQ, 2'b01, 2'b10));
      tbl.push_back(VD(I_BEQ, 2'b01, 2'b10));
      tbl.push_back(V(0, I_BEQ, 0, 5'b10000, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b00));
      // BNE not taken
      tbl.push_back(VF(I_BNE, 2'b01, 2'b10));
      tbl.push_back(VD(I_BNE, 2'b01, 2'b10));
      tbl.push_back(V(0, I_BNE, 0, 5'b00000, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b00));
      // CMP R0,#5 with ALUFlags=1000 in EXECUTEI
      tbl.push_back(VF(I_CMP, 2'b00, 2'b00));
      tbl.push_back(VD(I_CMP, 2'b00, 2'b00));
      tbl.push_back(V(0, I_CMP, 4'b1000, 5'b00000, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01));
      tbl.push_back(V(0, I_CMP, 0, 5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
      // ADDEQ R1,R1,#1 with Z=0: no write
      tbl.push_back(VF(I_ADDEQ, 2'b00, 2'b00));
      tbl.push_back(VD(I_ADDEQ, 2'b00, 2'b00));
      tbl.push_back(V(0, I_ADDEQ, 0, 5'b00000, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00));
      tbl.push_back(V(0, I_ADDEQ, 0, 5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
      // ADD R15,R0,R1: PC written in ALUWB
      tbl.push_back(VF(I_ADDPC, 2'b00, 2'b00));
      tbl.push_back(VD(I_ADDPC, 2'b00, 2'b00));
      tbl.push_back(V(0, I_ADDPC, 0, 5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
      tbl.push_back(V(0, I_ADDPC, 0, 5'b10100, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
      // BMI taken (N=1 from CMP)
      tbl.push_back(VF(I_BMI, 2'b01, 2'b10));
      tbl.push_back(VD(I_BMI, 2'b01, 2'b10));
      tbl.push_back(V(0, I_BMI, 0, 5'b10000, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b00));
      // STR interrupted by reset in MEMWR
      tbl.push_back(VF(I_STR, 2'b10, 2'b01));
      tbl.push_back(VD(I_STR, 2'b10, 2'b01));
      tbl.push_back(V(0, I_STR, 0, 5'b00000, 2'b10, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00));
      tbl.push_back(V(1, I_STR, 0, 5'b00000, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01, 2'b00));
      // Op=11 word: FETCH, DECODE, back to FETCH
      tbl.push_back(VF(I_NOP, 2'b00, 2'b11));
      tbl.push_back(VD(I_NOP, 2'b00, 2'b11));
      // BMI now not taken: flags were cleared by reset
      tbl.push_back(VF(I_BMI, 2'b01, 2'b10));
      tbl.push_back(VD(I_BMI, 2'b01, 2'b10));
      tbl.push_back(V(0, I_BMI, 0, 5'b00000, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b00));

      foreach (tbl[i]) step(tbl[i], i);

      // reset held two cycles over ALUWB of a PC-writing ADD: nothing commits
      step(VF(I_ADDPC, 2'b00, 2'b00), 100);
      step(VD(I_ADDPC, 2'b00, 2'b00), 101);
      step(V(0, I_ADDPC, 0, 5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00), 102);
      step(V(1, I_ADDPC, 0, 5'b00000, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00), 103);
      step(V(1, I_ADDPC, 0, 5'b00000, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00), 104);
      step(VF(I_ADDPC, 2'b00, 2'b00), 105);

      // a string of Op=11 words with arbitrary cond/funct bits: 2 cycles each
      step(VD(I_ADDPC, 2'b00, 2'b00), 106);
      step(V(0, I_ADDPC, 0, 5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00), 107);
      step(V(0, I_ADDPC, 0, 5'b10100, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00), 108);
      for (int k = 0; k < 4; k++) begin
         logic [19:0] w;
         w = 20'($urandom) | 20'h0C000;
         step(VF(w, 2'b00, 2'b11), 200 + 2*k);
         step(VD(w, 2'b00, 2'b11), 201 + 2*k);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
